// File: rtl/param_reg_chk.sv
// Far-end checker for a register/pipeline: compares d_out against d_in delayed LAT clocks
// over N words, counting mismatches and capturing the first failing pair.
module param_reg_chk #(
  parameter int W     = 8,
  parameter int LAT   = 1,
  parameter int N     = 10,
  parameter int ERR_W = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     d_in,
  input  logic [W-1:0]     d_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_strb,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [W-1:0]     exp_data,
  output logic [W-1:0]     got_data
);

  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] dl [LAT];
  logic [4:0]   wait_cnt;
  logic [W-1:0] exp_word;
  logic         run_start;
  logic         mismatch;
  logic         last_cmp;

  assign exp_word = dl[LAT-1];
  assign busy     = (state == FILL) || (state == CHECK);

  always_comb begin
    state_nxt = state;
    run_start = 1'b0;
    mismatch  = 1'b0;
    last_cmp  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          run_start = 1'b1;
          state_nxt = (LAT > 1) ? FILL : CHECK;
        end
      end
      FILL: begin
        // FILL covers edges e1..e(LAT-1); wait_cnt equals edge index minus one
        if (wait_cnt == 5'(LAT - 2)) state_nxt = CHECK;
      end
      CHECK: begin
        mismatch = (d_out != exp_word);
        last_cmp = (chk_cnt == CNT_W'(N - 1));
        if (last_cmp) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < LAT; j++) dl[j] <= '0;
    end else begin
      dl[0] <= d_in;
      for (int j = 1; j < LAT; j++) dl[j] <= dl[j-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err_cnt  <= '0;
      chk_cnt  <= '0;
      exp_data <= '0;
      got_data <= '0;
      err_strb <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_strb <= mismatch;
      if (run_start) begin
        wait_cnt <= '0;
        err_cnt  <= '0;
        chk_cnt  <= '0;
        exp_data <= '0;
        got_data <= '0;
        done     <= 1'b0;
        pass     <= 1'b0;
      end else begin
        if (state == FILL) wait_cnt <= wait_cnt + 1'b1;
        if (state == CHECK) chk_cnt <= chk_cnt + 1'b1;
        if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        // err_cnt never returns to zero within a run, so zero marks the first miss
        if (mismatch && (err_cnt == '0)) begin
          exp_data <= exp_word;
          got_data <= d_out;
        end
        if (last_cmp) begin
          done <= 1'b1;
          pass <= (err_cnt == '0) && !mismatch;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_reg_chk.sv
// Directed bench: three checker instances (LAT=1, LAT=1 with 2-bit error count, LAT=3)
// fed from a shared stimulus stream and bench-side reference pipelines.
module tb_param_reg_chk;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] d_in;
  logic       corrupt;
  logic       sel3;
  logic [7:0] q1, q2, q3;
  logic [7:0] d_out_a, d_out_s, d_out_l;

  logic       busy_a, done_a, pass_a, strb_a;
  logic [7:0] err_a;
  logic [3:0] chk_a;
  logic [7:0] exp_a, got_a;

  logic       busy_s, done_s, pass_s, strb_s;
  logic [1:0] err_s;
  logic [3:0] chk_s;
  logic [7:0] exp_s, got_s;

  logic       busy_l, done_l, pass_l, strb_l;
  logic [7:0] err_l;
  logic [3:0] chk_l;
  logic [7:0] exp_l, got_l;

  int total = 0;
  int bad   = 0;

  int         done_at_a, done_at_l, nstrb_a, nstrb_s;
  logic       busy0, done0, pass_early;
  logic [3:0] chk0;
  logic [7:0] w [10];
  logic [7:0] wn;

  param_reg_chk #(.W(8), .LAT(1), .N(10), .ERR_W(8)) u_a (
    .clk(clk), .reset(reset), .start(start), .d_in(d_in), .d_out(d_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_strb(strb_a),
    .err_cnt(err_a), .chk_cnt(chk_a), .exp_data(exp_a), .got_data(got_a));

  param_reg_chk #(.W(8), .LAT(1), .N(10), .ERR_W(2)) u_s (
    .clk(clk), .reset(reset), .start(start), .d_in(d_in), .d_out(d_out_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_strb(strb_s),
    .err_cnt(err_s), .chk_cnt(chk_s), .exp_data(exp_s), .got_data(got_s));

  param_reg_chk #(.W(8), .LAT(3), .N(10), .ERR_W(8)) u_l (
    .clk(clk), .reset(reset), .start(start), .d_in(d_in), .d_out(d_out_l),
    .busy(busy_l), .done(done_l), .pass(pass_l), .err_strb(strb_l),
    .err_cnt(err_l), .chk_cnt(chk_l), .exp_data(exp_l), .got_data(got_l));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference devices under check: 1-stage register and 3-stage pipeline
  always @(posedge clk) begin
    q1 <= d_in;
    q2 <= q1;
    q3 <= q2;
  end

  assign d_out_a = corrupt ? 8'hA4 : q1;
  assign d_out_s = ~q1;
  assign d_out_l = sel3 ? q3 : q1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives edges e0..e13: words 0..9 from w, then a fixed filler pattern.
  task automatic run(input int hold, input int bad_idx);
    done_at_a  = -1;
    done_at_l  = -1;
    nstrb_a    = 0;
    nstrb_s    = 0;
    pass_early = 1'b0;
    for (int k = 0; k < 14; k++) begin
      start   = (k < hold);
      d_in    = (k < 10) ? w[k] : 8'(8'hF0 + k);
      corrupt = (k - 1 == bad_idx);
      step();
      if (k == 0) begin
        busy0 = busy_a; done0 = done_a; chk0 = chk_a;
      end
      if (done_a && done_at_a < 0) done_at_a = k;
      if (done_l && done_at_l < 0) done_at_l = k;
      if (strb_a) nstrb_a++;
      if (strb_s) nstrb_s++;
      if (pass_a && !done_a) pass_early = 1'b1;
    end
    start   = 1'b0;
    corrupt = 1'b0;
  endtask

  task automatic rand_words();
    for (int i = 0; i < 10; i++) w[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (7) step();
    total++; if ({busy_a, done_a, pass_a, strb_a, err_a, chk_a, exp_a, got_a} !== '0) begin bad++; $display("FAIL reset_a_outputs got=%h want=0", {busy_a, done_a, pass_a, strb_a, err_a, chk_a, exp_a, got_a}); end
    total++; if ({busy_s, done_s, pass_s, err_s, chk_s, busy_l, done_l, pass_l, err_l} !== '0) begin bad++; $display("FAIL reset_s_l_outputs got=%h want=0", {busy_s, done_s, pass_s, err_s, chk_s, busy_l, done_l, pass_l, err_l}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_clean();
    rand_words();
    run(1, 99);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL clean_busy_e0 got=%b want=1", busy0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL clean_done_e0 got=%b want=0", done0); end
    total++; if (done_at_a !== 10) begin bad++; $display("FAIL clean_done_at got=%0d want=10", done_at_a); end
    total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL clean_pass got=%b want=1", pass_a); end
    total++; if (err_a !== 8'd0) begin bad++; $display("FAIL clean_err_cnt got=%0d want=0", err_a); end
    total++; if (chk_a !== 4'd10) begin bad++; $display("FAIL clean_chk_cnt got=%0d want=10", chk_a); end
    total++; if (nstrb_a !== 0) begin bad++; $display("FAIL clean_strb got=%0d want=0", nstrb_a); end
    total++; if (pass_early !== 1'b0) begin bad++; $display("FAIL clean_pass_before_done got=%b want=0", pass_early); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL clean_busy_end got=%b want=0", busy_a); end
  endtask

  task automatic test_corrupt();
    rand_words();
    w[3] = 8'hA5;
    run(1, 3);
    total++; if (nstrb_a !== 1) begin bad++; $display("FAIL corrupt_strb got=%0d want=1", nstrb_a); end
    total++; if (err_a !== 8'd1) begin bad++; $display("FAIL corrupt_err_cnt got=%0d want=1", err_a); end
    total++; if (exp_a !== 8'hA5) begin bad++; $display("FAIL corrupt_exp got=%h want=a5", exp_a); end
    total++; if (got_a !== 8'hA4) begin bad++; $display("FAIL corrupt_got got=%h want=a4", got_a); end
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL corrupt_done got=%b want=1", done_a); end
    total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL corrupt_pass got=%b want=0", pass_a); end
  endtask

  task automatic test_saturation();
    rand_words();
    wn = ~w[0];
    run(1, 99);
    total++; if (err_s !== 2'd3) begin bad++; $display("FAIL sat_err_cnt got=%0d want=3", err_s); end
    total++; if (chk_s !== 4'd10) begin bad++; $display("FAIL sat_chk_cnt got=%0d want=10", chk_s); end
    total++; if (exp_s !== w[0]) begin bad++; $display("FAIL sat_exp got=%h want=%h", exp_s, w[0]); end
    total++; if (got_s !== wn) begin bad++; $display("FAIL sat_got got=%h want=%h", got_s, wn); end
    total++; if (nstrb_s !== 10) begin bad++; $display("FAIL sat_strb got=%0d want=10", nstrb_s); end
    total++; if ({done_s, pass_s} !== 2'b10) begin bad++; $display("FAIL sat_done_pass got=%b want=10", {done_s, pass_s}); end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 10; i++) w[i] = 8'(i + 1);
    sel3 = 1'b1;
    run(1, 99);
    total++; if (done_at_l !== 12) begin bad++; $display("FAIL lat3_done_at got=%0d want=12", done_at_l); end
    total++; if (pass_l !== 1'b1) begin bad++; $display("FAIL lat3_pass got=%b want=1", pass_l); end
    total++; if (err_l !== 8'd0) begin bad++; $display("FAIL lat3_err_cnt got=%0d want=0", err_l); end
    sel3 = 1'b0;
    run(1, 99);
    total++; if (err_l !== 8'd10) begin bad++; $display("FAIL lat_mis_err_cnt got=%0d want=10", err_l); end
    total++; if (pass_l !== 1'b0) begin bad++; $display("FAIL lat_mis_pass got=%b want=0", pass_l); end
    total++; if (chk_l !== 4'd10) begin bad++; $display("FAIL lat_mis_chk_cnt got=%0d want=10", chk_l); end
    total++; if (exp_l !== 8'h01 || got_l !== 8'h03) begin bad++; $display("FAIL lat_mis_pair got=%h/%h want=01/03", exp_l, got_l); end
  endtask

  task automatic test_reset_mid();
    rand_words();
    start = 1'b1;
    d_in  = w[0];
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      d_in = w[k];
      step();
    end
    total++; if (chk_a !== 4'd4) begin bad++; $display("FAIL mid_chk_before got=%0d want=4", chk_a); end
    total++; if (err_s !== 2'd3) begin bad++; $display("FAIL mid_err_s_before got=%0d want=3", err_s); end
    reset = 1'b1;
    #1;
    total++; if ({busy_a, done_a, pass_a, strb_a, err_a, chk_a, exp_a, got_a} !== '0) begin bad++; $display("FAIL mid_reset_a got=%h want=0", {busy_a, done_a, pass_a, strb_a, err_a, chk_a, exp_a, got_a}); end
    total++; if ({busy_s, strb_s, err_s, chk_s, exp_s, got_s} !== '0) begin bad++; $display("FAIL mid_reset_s got=%h want=0", {busy_s, strb_s, err_s, chk_s, exp_s, got_s}); end
    step();
    reset = 1'b0;
    step();
    rand_words();
    run(1, 99);
    total++; if (chk0 !== 4'd0) begin bad++; $display("FAIL mid_rerun_chk_e0 got=%0d want=0", chk0); end
    total++; if (chk_a !== 4'd10) begin bad++; $display("FAIL mid_rerun_chk got=%0d want=10", chk_a); end
    total++; if (done_at_a !== 10) begin bad++; $display("FAIL mid_rerun_done_at got=%0d want=10", done_at_a); end
    total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL mid_rerun_pass got=%b want=1", pass_a); end
  endtask

  task automatic test_start_hold();
    rand_words();
    run(10, 99);
    total++; if (done_at_a !== 10) begin bad++; $display("FAIL hold_done_at got=%0d want=10", done_at_a); end
    total++; if (chk_a !== 4'd10) begin bad++; $display("FAIL hold_chk_cnt got=%0d want=10", chk_a); end
    total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL hold_pass got=%b want=1", pass_a); end
  endtask

  task automatic test_restart();
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL restart_pre_done got=%b want=1", done_a); end
    rand_words();
    run(1, 99);
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL restart_done_e0 got=%b want=0", done0); end
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL restart_busy_e0 got=%b want=1", busy0); end
    total++; if (chk0 !== 4'd0) begin bad++; $display("FAIL restart_chk_e0 got=%0d want=0", chk0); end
    total++; if (done_at_a !== 10) begin bad++; $display("FAIL restart_done_at got=%0d want=10", done_at_a); end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    d_in    = 8'h00;
    corrupt = 1'b0;
    sel3    = 1'b0;
    test_reset();
    test_clean();
    test_corrupt();
    test_saturation();
    test_latency();
    test_reset_mid();
    test_start_hold();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
